// File: rtl/coin_acceptor.sv
// Coin slot front end: synchronizes and debounces the raw sensors, buffers detected coins, and emits c/a strobes.
// Optional running total of delivered cents is enabled by defining COIN_ACCEPTOR_TOTAL_EN.
module coin_acceptor #(
    parameter int          DEBOUNCE   = 4,
    parameter int          FIFO_DEPTH = 4,
    parameter int          GAP        = 1,
    parameter logic [7:0]  NICKEL     = 8'd5,
    parameter logic [7:0]  DIME       = 8'd10,
    parameter logic [7:0]  QUARTER    = 8'd25
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          nickel_in,
    input  logic                          dime_in,
    input  logic                          quarter_in,
    input  logic                          accept_en,
`ifdef COIN_ACCEPTOR_TOTAL_EN
    input  logic                          clear_total,
    output logic [15:0]                   total,
`endif
    output logic                          c,
    output logic [7:0]                    a,
    output logic                          reject,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int              AW     = $clog2(FIFO_DEPTH);
    localparam logic [3:0]      DB_MAX = 4'(DEBOUNCE);
    localparam logic [3:0]      GAP_LD = 4'(GAP);
    localparam logic [AW:0]     DEPTH  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_GAP
    } state_t;

    state_t         state, state_next;
    logic [2:0]     raw;
    logic [2:0]     sync_a, sync_b;
    logic [3:0]     db_cnt [3];
    logic [2:0]     det;
    logic           cand_valid;
    logic           multi;
    logic [7:0]     cand_value;
    logic           push, pop;
    logic           full, empty;
    logic           reject_next;
    logic           c_next;
    logic [7:0]     a_next;
    logic [3:0]     gap_cnt, gap_next;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    level;
    logic [7:0]     mem [FIFO_DEPTH];

    assign raw = {quarter_in, dime_in, nickel_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Counters saturate at DB_MAX, so each high level detects exactly once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned ch = 0; ch < 3; ch++) begin
                db_cnt[ch] <= '0;
            end
        end else begin
            for (int unsigned ch = 0; ch < 3; ch++) begin
                if (!sync_b[ch]) begin
                    db_cnt[ch] <= '0;
                end else if (db_cnt[ch] != DB_MAX) begin
                    db_cnt[ch] <= db_cnt[ch] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned ch = 0; ch < 3; ch++) begin
            det[ch] = sync_b[ch] && (db_cnt[ch] == DB_MAX - 4'd1);
        end
    end

    always_comb begin
        cand_valid = |det;
        multi      = (det[0] & det[1]) | (det[0] & det[2]) | (det[1] & det[2]);
        if (det[2]) begin
            cand_value = QUARTER;
        end else if (det[1]) begin
            cand_value = DIME;
        end else begin
            cand_value = NICKEL;
        end
    end

    assign full  = (level == DEPTH);
    assign empty = (level == '0);

    // A pop on the same edge frees the slot, so a full buffer can still take a coin.
    assign push        = cand_valid && accept_en && (!full || pop);
    assign reject_next = multi || (cand_valid && !push);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cand_value;
        end
    end

    assign fifo_level = level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            c       <= 1'b0;
            a       <= '0;
            reject  <= 1'b0;
            gap_cnt <= '0;
        end else begin
            state   <= state_next;
            c       <= c_next;
            a       <= a_next;
            reject  <= reject_next;
            gap_cnt <= gap_next;
        end
    end

    always_comb begin
        state_next = state;
        c_next     = 1'b0;
        a_next     = a;
        gap_next   = gap_cnt;
        pop        = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    a_next     = mem[rd_ptr];
                    c_next     = 1'b1;
                    state_next = S_PULSE;
                end
            end
            S_PULSE: begin
                gap_next   = GAP_LD;
                state_next = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt <= 4'd1) begin
                    state_next = S_IDLE;
                end else begin
                    gap_next = gap_cnt - 4'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

`ifdef COIN_ACCEPTOR_TOTAL_EN
    logic [16:0] total_sum;

    assign total_sum = {1'b0, total} + {9'd0, a};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total <= '0;
        end else if (clear_total) begin
            total <= '0;
        end else if (c) begin
            total <= total_sum[16] ? '1 : total_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Randomized self-checking bench for coin_acceptor against a sample-history / queue reference model.
// Define COIN_ACCEPTOR_TOTAL_EN for both files to cover the running total.
module tb_coin_acceptor;

    localparam int          DEBOUNCE   = 4;
    localparam int          FIFO_DEPTH = 4;
    localparam int          GAP        = 1;
    localparam logic [7:0]  NICKEL     = 8'd5;
    localparam logic [7:0]  DIME       = 8'd10;
    localparam logic [7:0]  QUARTER    = 8'd25;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic                         nickel_in = 1'b0;
    logic                         dime_in = 1'b0;
    logic                         quarter_in = 1'b0;
    logic                         accept_en = 1'b1;
    logic                         c;
    logic [7:0]                   a;
    logic                         reject;
    logic [$clog2(FIFO_DEPTH):0]  fifo_level;
`ifdef COIN_ACCEPTOR_TOTAL_EN
    logic                         clear_total = 1'b0;
    logic [15:0]                  total;
    int unsigned                  m_total;
`endif

    coin_acceptor #(
        .DEBOUNCE   (DEBOUNCE),
        .FIFO_DEPTH (FIFO_DEPTH),
        .GAP        (GAP),
        .NICKEL     (NICKEL),
        .DIME       (DIME),
        .QUARTER    (QUARTER)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .nickel_in  (nickel_in),
        .dime_in    (dime_in),
        .quarter_in (quarter_in),
        .accept_en  (accept_en),
`ifdef COIN_ACCEPTOR_TOTAL_EN
        .clear_total(clear_total),
        .total      (total),
`endif
        .c          (c),
        .a          (a),
        .reject     (reject),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int unsigned  hist [3];
    logic [7:0]   mdl_q [$];
    int           now;
    int           next_ok;
    logic         exp_c;
    logic [7:0]   exp_a;
    logic         exp_rej;

    // per-segment observations
    int           strobe_n, reject_n, seg_tick, first_c, max_level;
    logic [7:0]   last_a;

    // random generator state
    int           rem [3];
    logic [2:0]   lvl;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, want);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) hist[i] = 0;
        mdl_q.delete();
        now     = 0;
        next_ok = 0;
        exp_c   = 1'b0;
        exp_a   = '0;
        exp_rej = 1'b0;
`ifdef COIN_ACCEPTOR_TOTAL_EN
        m_total = 0;
`endif
    endfunction

    // A coin is seen at edge t when the raw line was sampled high at edges
    // t-2 .. t-DEBOUNCE-1 and low at t-DEBOUNCE-2 (two synchronizer stages).
    function automatic void model_step();
        int unsigned mask;
        logic [2:0]  rawv;
        logic [2:0]  det;
        int          ndet;
        logic [7:0]  val;
        bit          pop, push;
        mask = (32'd1 << DEBOUNCE) - 1;
        rawv = {quarter_in, dime_in, nickel_in};
`ifdef COIN_ACCEPTOR_TOTAL_EN
        if (clear_total) m_total = 0;
        else if (exp_c) m_total = (m_total + exp_a > 65535) ? 65535 : m_total + exp_a;
`endif
        for (int i = 0; i < 3; i++) begin
            hist[i] = (hist[i] << 1) | {31'd0, rawv[i]};
            det[i]  = (((hist[i] >> 2) & mask) == mask) && (((hist[i] >> (DEBOUNCE + 2)) & 1) == 0);
        end
        ndet = $countones(det);
        val  = det[2] ? QUARTER : (det[1] ? DIME : NICKEL);
        now++;
        pop  = (mdl_q.size() != 0) && (now >= next_ok);
        exp_c = pop;
        if (pop) begin
            exp_a   = mdl_q.pop_front();
            next_ok = now + GAP + 2;
        end
        push = (ndet > 0) && accept_en && (mdl_q.size() < FIFO_DEPTH);
        if (push) mdl_q.push_back(val);
        exp_rej = (ndet > 1) || (ndet == 1 && !push);
    endfunction

    task automatic clear_stats();
        strobe_n  = 0;
        reject_n  = 0;
        seg_tick  = 0;
        first_c   = -1;
        max_level = 0;
        last_a    = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("c", c, exp_c);
        check("a", a, exp_a);
        check("reject", reject, exp_rej);
        check("fifo_level", fifo_level, mdl_q.size());
`ifdef COIN_ACCEPTOR_TOTAL_EN
        check("total", total, m_total);
`endif
        if (c) begin
            strobe_n++;
            last_a = a;
            if (first_c < 0) first_c = seg_tick;
        end
        if (reject) reject_n++;
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        seg_tick++;
    endtask

    task automatic set_lines(input logic n, input logic d, input logic q);
        nickel_in  = n;
        dime_in    = d;
        quarter_in = q;
    endtask

    task automatic idle(input int n);
        set_lines(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Called at a negedge; leaves rst released at the following negedge.
    task automatic reset_dut();
        rst = 1'b1;
        set_lines(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) rem[i] = 0;
        lvl = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_stats();
    endtask

    task automatic random_lines(input int hi_max, input int lo_max);
        for (int i = 0; i < 3; i++) begin
            if (rem[i] == 0) begin
                lvl[i] = ~lvl[i];
                rem[i] = lvl[i] ? int'($urandom_range(hi_max, 1)) : int'($urandom_range(lo_max, 1));
            end
            rem[i]--;
        end
        set_lines(lvl[0], lvl[1], lvl[2]);
    endtask

    initial begin
        model_reset();
        clear_stats();
        @(negedge clk);
        check("rst_c", c, 1'b0);
        check("rst_a", a, 8'd0);
        check("rst_reject", reject, 1'b0);
        check("rst_level", fifo_level, 0);
        reset_dut();

        // single quarter, 10 cycles high
        set_lines(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        idle(15);
        check("q_strobes", strobe_n, 1);
        check("q_latency", first_c, DEBOUNCE + 2);
        check("q_value", last_a, QUARTER);
        check("q_rejects", reject_n, 0);

        // short dime pulse is filtered out
        clear_stats();
        set_lines(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < DEBOUNCE - 1; i++) tick();
        idle(15);
        check("short_strobes", strobe_n, 0);
        check("short_rejects", reject_n, 0);
        check("short_level", max_level, 0);

        // six nickels, 5 high / 1 low
        clear_stats();
        for (int k = 0; k < 6; k++) begin
            set_lines(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 5; i++) tick();
            set_lines(1'b0, 1'b0, 1'b0);
            tick();
        end
        idle(30);
        check("nickel_strobes", strobe_n, 6);
        check("nickel_rejects", reject_n, 0);
        check("nickel_value", last_a, NICKEL);

        // dime and quarter rise together
        clear_stats();
        set_lines(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) tick();
        idle(15);
        check("dual_strobes", strobe_n, 1);
        check("dual_value", last_a, QUARTER);
        check("dual_rejects", reject_n, 1);

        // coin while accept_en is low
        clear_stats();
        accept_en = 1'b0;
        set_lines(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        idle(12);
        accept_en = 1'b1;
        check("dis_strobes", strobe_n, 0);
        check("dis_rejects", reject_n, 1);

        // staggered bursts on all three lines overflow the buffer
        clear_stats();
        for (int t = 0; t < 45; t++) begin
            set_lines((t % 5) != 4,
                      (t >= 1) && (((t - 1) % 5) != 4),
                      (t >= 2) && (((t - 2) % 5) != 4));
            tick();
        end
        idle(40);
        check("burst_full", max_level, FIFO_DEPTH);
        check("burst_rejected", reject_n > 0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            accept_en = ($urandom_range(7, 0) != 0);
`ifdef COIN_ACCEPTOR_TOTAL_EN
            clear_total = ($urandom_range(63, 0) == 0);
`endif
            random_lines(9, 4);
            tick();
        end
        accept_en = 1'b1;
`ifdef COIN_ACCEPTOR_TOTAL_EN
        clear_total = 1'b0;
`endif
        idle(30);

        // asynchronous reset in the middle of a strobe
        clear_stats();
        set_lines(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 30 && !c; i++) tick();
        check("mid_strobe_seen", c, 1'b1);
        rst = 1'b1;
        #1;
        check("arst_c", c, 1'b0);
        check("arst_reject", reject, 1'b0);
        check("arst_a", a, 8'd0);
        check("arst_level", fifo_level, 0);
`ifdef COIN_ACCEPTOR_TOTAL_EN
        check("arst_total", total, 16'd0);
`endif
        reset_dut();

        for (int i = 0; i < 400; i++) begin
            random_lines(6, 3);
            tick();
        end
        idle(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
